weight_storage_port_arbiter: RTL and testbench
==============================================

Name: weight_storage_port_arbiter

Overview:
- Shares the weight storage between two requesters: the host weight loader (initial write) and the backprop update engine (dc_dw update).
- Issues at most one storage operation per cycle as registered is_write/is_update pulses.
- Bounds starvation with a burst counter; the controller can stall all access with hold_off.
- Sits between the load/update sources and the weight_storage write and update_weight interfaces of data_path.

Parameters:
DATA_WIDTH, 48, packed weight word (three 16-bit fixed-point lanes)
INDEX_WIDTH, 32, layer/row index width
MAX_BURST, 4, max consecutive grants to one requester while the other is waiting (>=1)

Ports:
clk_clk  input  1  clock, all state on rising edge
reset_reset_n  input  1  asynchronous, active-low reset
training_mode  input  1  1: update requester preferred; 0: host preferred
hold_off  input  1  controller stall; forces both readies low
flush  input  1  synchronous; clears arbitration state and counter
host_wr_valid  input  1  host write request
host_wr_ready  output  1  host request accepted this cycle (valid&ready)
host_wr_layer_index  input  INDEX_WIDTH  target layer
host_wr_row_index  input  INDEX_WIDTH  target row
host_wr_data  input  DATA_WIDTH  weight word
upd_valid  input  1  update request
upd_ready  output  1  update request accepted this cycle
upd_layer_index  input  INDEX_WIDTH  target layer
upd_row_index  input  INDEX_WIDTH  target row
upd_dc_dw  input  DATA_WIDTH  gradient word
ws_is_write  output  1  one-cycle write strobe to weight storage
ws_write_layer_index  output  INDEX_WIDTH  registered host layer
ws_write_row_index  output  INDEX_WIDTH  registered host row
ws_write_data  output  DATA_WIDTH  registered host data
ws_is_update  output  1  one-cycle update strobe to weight storage
ws_update_layer_index  output  INDEX_WIDTH  registered update layer
ws_update_row_index  output  INDEX_WIDTH  registered update row
ws_update_dc_dw  output  DATA_WIDTH  registered gradient
busy  output  1  strobe in flight or any valid pending

Behaviour:
- Reset (async, reset_reset_n=0): all outputs 0, state IDLE, burst_cnt=0. A strobe registered before reset is dropped.
- Readies are combinational from state, valids, training_mode and hold_off. Never both high in one cycle. Never high while hold_off=1 or flush=1.
- Accept on valid&ready at edge N. Next cycle (N+1) the matching ws_is_* strobe is 1 for exactly one cycle with the captured fields. Latency is 1 cycle; throughput is 1 op/cycle.
- ws_is_write and ws_is_update are mutually exclusive. Field registers hold their last value when no strobe is issued.
- FSM states: IDLE, HOST_BURST, UPD_BURST.
- IDLE: if only one valid, grant it. If both valid, grant the preferred requester (upd if training_mode=1, else host). Go to that requester's BURST state with burst_cnt=1.
- X_BURST: if X is valid and (the other is not valid or burst_cnt<MAX_BURST), grant X and increment burst_cnt (saturating at MAX_BURST).
- X_BURST, other requester valid and (X not valid or burst_cnt==MAX_BURST): grant the other, move to its BURST state, burst_cnt=1.
- X_BURST, neither valid: return to IDLE, burst_cnt=0.
- hold_off=1: no grant; state and burst_cnt frozen. A strobe already registered still issues.
- flush=1: state IDLE, burst_cnt=0, no grant that cycle. A registered strobe still issues.
- Ordering: operations reach storage strictly in grant order. The same layer/row requested by both in one cycle resolves by arbitration order; no merging.
- A requester must hold valid and fields stable until ready. Dropping valid before ready is legal; nothing is issued.
- busy = ws_is_write | ws_is_update | host_wr_valid | upd_valid.

Decomposition:
- Shared package: DATA_WIDTH/INDEX_WIDTH constants, arbiter state enum (IDLE/HOST_BURST/UPD_BURST), packed request struct {layer_index, row_index, data}.
- One natural sub-module: weight_storage_issue_reg, the registered output stage that captures the granted request and emits the one-cycle strobe.

Test Plan:
- Reset mid-burst: host_wr_valid=1 with layer 2 / row 5 accepted, reset_reset_n=0 that cycle -> ws_is_write stays 0, all outputs 0, state IDLE.
- Host only: 3 back-to-back writes to rows 0,1,2, data 0x0001_0002_0003 -> ws_is_write high 3 consecutive cycles starting 1 cycle after the first accept, rows 0,1,2 in order.
- Contention, training_mode=1, MAX_BURST=4, both valid for 10 cycles -> grant pattern U,U,U,U,H,H,H,H,U,U; readies never both 1.
- Contention, training_mode=0, upd_valid only for 1 cycle -> single ws_is_update. With host_wr_valid present from the start, the host wins the first grant.
- hold_off=1 for 3 cycles while both valid, with a strobe registered just before -> that strobe issues, then 3 cycles of no strobe. After hold_off drops, the grant resumes the frozen state with the same burst_cnt.
- flush during UPD_BURST with burst_cnt=3 -> no grant that cycle. Next cycle, with both valid and training_mode=0, the host is granted (IDLE preference).

Source files
------------

// File: rtl/weight_storage_port_arbiter_pkg.sv
// rtl/weight_storage_port_arbiter_pkg.sv - shared types for the weight storage port arbiter
//
// Purpose: word/index widths, arbiter state encoding and the packed request
// record that carries one storage operation from a requester to the issue stage.
// Ports: none (package).

package weight_storage_port_arbiter_pkg;

  localparam int DATA_WIDTH  = 48;
  localparam int INDEX_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_HOST_BURST = 2'd1,
    ST_UPD_BURST  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [INDEX_WIDTH-1:0] layer_index;
    logic [INDEX_WIDTH-1:0] row_index;
    logic [DATA_WIDTH-1:0]  data;
  } ws_req_t;

endpackage

// File: rtl/weight_storage_port_arbiter_issue_reg.sv
// rtl/weight_storage_port_arbiter_issue_reg.sv - registered issue stage driving weight storage
//
// Purpose: captures the granted request and emits a one-cycle write or update
// strobe on the following cycle. Field registers only load on a grant, so
// they keep their last value between strobes.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   i_wr_grant, i_wr_req     host write granted this cycle and its fields
//   i_upd_grant, i_upd_req   update granted this cycle and its fields
//   o_is_write, o_wr_req     write strobe and captured host fields
//   o_is_update, o_upd_req   update strobe and captured update fields

module weight_storage_issue_reg
  import weight_storage_port_arbiter_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    i_wr_grant,
  input  ws_req_t i_wr_req,
  input  logic    i_upd_grant,
  input  ws_req_t i_upd_req,
  output logic    o_is_write,
  output ws_req_t o_wr_req,
  output logic    o_is_update,
  output ws_req_t o_upd_req
);

  logic    r_is_write;
  logic    r_is_update;
  ws_req_t r_wr_req;
  ws_req_t r_upd_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_write  <= 1'b0;
      r_is_update <= 1'b0;
      r_wr_req    <= '0;
      r_upd_req   <= '0;
    end else begin
      r_is_write  <= i_wr_grant;
      r_is_update <= i_upd_grant;
      if (i_wr_grant) begin
        r_wr_req <= i_wr_req;
      end
      if (i_upd_grant) begin
        r_upd_req <= i_upd_req;
      end
    end
  end

  assign o_is_write  = r_is_write;
  assign o_is_update = r_is_update;
  assign o_wr_req    = r_wr_req;
  assign o_upd_req   = r_upd_req;

endmodule

// File: rtl/weight_storage_port_arbiter.sv
// rtl/weight_storage_port_arbiter.sv - two-requester arbiter in front of weight storage
//
// Purpose: shares the weight storage between the host weight loader and the
// backprop update engine. At most one operation is granted per cycle; the
// granted request is issued one cycle later as ws_is_write or ws_is_update.
// A burst counter bounds how long one requester can hold the port while the
// other waits; hold_off stalls all grants, flush returns arbitration to IDLE.
// Ports:
//   clk_clk, reset_reset_n          clock, asynchronous active-low reset
//   training_mode, hold_off, flush  preference select, stall, arbitration clear
//   host_wr_*                       host write request, ready = accepted
//   upd_*                           update request, ready = accepted
//   ws_is_write, ws_write_*         write strobe and fields to storage
//   ws_is_update, ws_update_*       update strobe and fields to storage
//   busy                            strobe in flight or a request pending

module weight_storage_port_arbiter
  import weight_storage_port_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset_n,
  input  logic                   training_mode,
  input  logic                   hold_off,
  input  logic                   flush,
  input  logic                   host_wr_valid,
  output logic                   host_wr_ready,
  input  logic [INDEX_WIDTH-1:0] host_wr_layer_index,
  input  logic [INDEX_WIDTH-1:0] host_wr_row_index,
  input  logic [DATA_WIDTH-1:0]  host_wr_data,
  input  logic                   upd_valid,
  output logic                   upd_ready,
  input  logic [INDEX_WIDTH-1:0] upd_layer_index,
  input  logic [INDEX_WIDTH-1:0] upd_row_index,
  input  logic [DATA_WIDTH-1:0]  upd_dc_dw,
  output logic                   ws_is_write,
  output logic [INDEX_WIDTH-1:0] ws_write_layer_index,
  output logic [INDEX_WIDTH-1:0] ws_write_row_index,
  output logic [DATA_WIDTH-1:0]  ws_write_data,
  output logic                   ws_is_update,
  output logic [INDEX_WIDTH-1:0] ws_update_layer_index,
  output logic [INDEX_WIDTH-1:0] ws_update_row_index,
  output logic [DATA_WIDTH-1:0]  ws_update_dc_dw,
  output logic                   busy
);

  localparam int               CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_e       r_state;
  logic [CNT_W-1:0] r_burst_cnt;

  logic    w_grant_host;
  logic    w_grant_upd;
  logic    w_burst_open;
  ws_req_t w_host_req;
  ws_req_t w_upd_req;
  ws_req_t w_ws_wr_req;
  ws_req_t w_ws_upd_req;

  // The current owner may keep going while the other waits only below the cap.
  assign w_burst_open = (r_burst_cnt < CNT_MAX);

  // Grants are the readies. Gating with reset keeps an in-reset requester
  // from seeing an acceptance that the registers will never capture.
  always_comb begin
    w_grant_host = 1'b0;
    w_grant_upd  = 1'b0;
    if (reset_reset_n && !hold_off && !flush) begin
      case (r_state)
        ST_IDLE: begin
          if (host_wr_valid && upd_valid) begin
            w_grant_upd  = training_mode;
            w_grant_host = !training_mode;
          end else begin
            w_grant_host = host_wr_valid;
            w_grant_upd  = upd_valid;
          end
        end
        ST_HOST_BURST: begin
          if (host_wr_valid && (!upd_valid || w_burst_open)) begin
            w_grant_host = 1'b1;
          end else begin
            w_grant_upd = upd_valid;
          end
        end
        ST_UPD_BURST: begin
          if (upd_valid && (!host_wr_valid || w_burst_open)) begin
            w_grant_upd = 1'b1;
          end else begin
            w_grant_host = host_wr_valid;
          end
        end
        default: begin
          w_grant_host = 1'b0;
          w_grant_upd  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state     <= ST_IDLE;
      r_burst_cnt <= '0;
    end else if (flush) begin
      r_state     <= ST_IDLE;
      r_burst_cnt <= '0;
    end else if (!hold_off) begin
      if (w_grant_host) begin
        if (r_state == ST_HOST_BURST) begin
          if (w_burst_open) begin
            r_burst_cnt <= r_burst_cnt + CNT_ONE;
          end
        end else begin
          r_state     <= ST_HOST_BURST;
          r_burst_cnt <= CNT_ONE;
        end
      end else if (w_grant_upd) begin
        if (r_state == ST_UPD_BURST) begin
          if (w_burst_open) begin
            r_burst_cnt <= r_burst_cnt + CNT_ONE;
          end
        end else begin
          r_state     <= ST_UPD_BURST;
          r_burst_cnt <= CNT_ONE;
        end
      end else begin
        r_state     <= ST_IDLE;
        r_burst_cnt <= '0;
      end
    end
  end

  assign w_host_req = '{layer_index: host_wr_layer_index,
                        row_index:   host_wr_row_index,
                        data:        host_wr_data};
  assign w_upd_req  = '{layer_index: upd_layer_index,
                        row_index:   upd_row_index,
                        data:        upd_dc_dw};

  weight_storage_issue_reg u_issue (
    .clk         (clk_clk),
    .rst_n       (reset_reset_n),
    .i_wr_grant  (w_grant_host),
    .i_wr_req    (w_host_req),
    .i_upd_grant (w_grant_upd),
    .i_upd_req   (w_upd_req),
    .o_is_write  (ws_is_write),
    .o_wr_req    (w_ws_wr_req),
    .o_is_update (ws_is_update),
    .o_upd_req   (w_ws_upd_req)
  );

  assign host_wr_ready         = w_grant_host;
  assign upd_ready             = w_grant_upd;
  assign ws_write_layer_index  = w_ws_wr_req.layer_index;
  assign ws_write_row_index    = w_ws_wr_req.row_index;
  assign ws_write_data         = w_ws_wr_req.data;
  assign ws_update_layer_index = w_ws_upd_req.layer_index;
  assign ws_update_row_index   = w_ws_upd_req.row_index;
  assign ws_update_dc_dw       = w_ws_upd_req.data;
  assign busy = ws_is_write | ws_is_update | host_wr_valid | upd_valid;

endmodule

// File: tb/tb_weight_storage_port_arbiter.sv
// tb/tb_weight_storage_port_arbiter.sv - self-checking bench for weight_storage_port_arbiter

module tb_weight_storage_port_arbiter;

  localparam int DW   = 48;
  localparam int IW   = 32;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, tm, hold_off, flush;
  logic          hv, uv;
  logic [IW-1:0] hl, hr, ul, ur;
  logic [DW-1:0] hd, ud;
  logic          host_wr_ready, upd_ready, ws_is_write, ws_is_update, busy;
  logic [IW-1:0] ws_wl, ws_wr, ws_ul, ws_ur;
  logic [DW-1:0] ws_wd, ws_ud;

  weight_storage_port_arbiter #(.MAX_BURST(MAXB)) dut (
    .clk_clk               (clk),
    .reset_reset_n         (rst_n),
    .training_mode         (tm),
    .hold_off              (hold_off),
    .flush                 (flush),
    .host_wr_valid         (hv),
    .host_wr_ready         (host_wr_ready),
    .host_wr_layer_index   (hl),
    .host_wr_row_index     (hr),
    .host_wr_data          (hd),
    .upd_valid             (uv),
    .upd_ready             (upd_ready),
    .upd_layer_index       (ul),
    .upd_row_index         (ur),
    .upd_dc_dw             (ud),
    .ws_is_write           (ws_is_write),
    .ws_write_layer_index  (ws_wl),
    .ws_write_row_index    (ws_wr),
    .ws_write_data         (ws_wd),
    .ws_is_update          (ws_is_update),
    .ws_update_layer_index (ws_ul),
    .ws_update_row_index   (ws_ur),
    .ws_update_dc_dw       (ws_ud),
    .busy                  (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: who owns the port (0 none, 1 host, 2 update), how many
  // consecutive grants it has had, and what storage must see next cycle.
  int            m_owner, m_run, last_g;
  logic          e_wr, e_upd;
  logic [IW-1:0] e_wl, e_wrow, e_ul, e_urow;
  logic [DW-1:0] e_wd, e_ud;
  string         pat;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_run = 0; last_g = 0;
    e_wr = 0; e_upd = 0;
    e_wl = '0; e_wrow = '0; e_wd = '0;
    e_ul = '0; e_urow = '0; e_ud = '0;
  endtask

  function automatic int model_grant();
    if (!rst_n || hold_off || flush) return 0;
    if (!hv && !uv) return 0;
    if (hv && !uv) return 1;
    if (uv && !hv) return 2;
    if (m_owner == 0) return tm ? 2 : 1;
    if (m_run < MAXB) return m_owner;
    return 3 - m_owner;
  endfunction

  task automatic model_advance(input int g);
    e_wr  = (g == 1);
    e_upd = (g == 2);
    if (g == 1) begin e_wl = hl; e_wrow = hr; e_wd = hd; end
    if (g == 2) begin e_ul = ul; e_urow = ur; e_ud = ud; end
    if (flush) begin
      m_owner = 0; m_run = 0;
    end else if (!hold_off) begin
      if (g == 0) begin
        m_owner = 0; m_run = 0;
      end else if (g == m_owner) begin
        m_run = (m_run + 1 > MAXB) ? MAXB : m_run + 1;
      end else begin
        m_owner = g; m_run = 1;
      end
    end
  endtask

  task automatic check_outputs();
    cmp("ws_is_write", ws_is_write, e_wr);
    cmp("ws_is_update", ws_is_update, e_upd);
    cmp("ws_write_layer", ws_wl, e_wl);
    cmp("ws_write_row", ws_wr, e_wrow);
    cmp("ws_write_data", ws_wd, e_wd);
    cmp("ws_update_layer", ws_ul, e_ul);
    cmp("ws_update_row", ws_ur, e_urow);
    cmp("ws_update_dc_dw", ws_ud, e_ud);
  endtask

  // One clock: check the combinational readies/busy for the driven inputs,
  // take the edge, then check the registered strobes against the model.
  task automatic step();
    int g;
    #1;
    g = model_grant();
    cmp("host_wr_ready", host_wr_ready, (g == 1));
    cmp("upd_ready", upd_ready, (g == 2));
    cmp("ready_exclusive", host_wr_ready & upd_ready, 0);
    cmp("busy", busy, e_wr | e_upd | hv | uv);
    @(posedge clk);
    last_g = g;
    model_advance(g);
    #1;
    check_outputs();
  endtask

  function automatic string gchar(input int g);
    return (g == 2) ? "U" : (g == 1) ? "H" : "-";
  endfunction

  task automatic check_pat(input string name, input string exp);
    n_vec++;
    if (pat != exp) begin
      n_err++;
      $display("FAIL %s: got %s expected %s", name, pat, exp);
    end
  endtask

  initial begin
    rst_n = 0; tm = 0; hold_off = 0; flush = 0;
    hv = 0; uv = 0; hl = '0; hr = '0; hd = '0; ul = '0; ur = '0; ud = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    cmp("reset_busy", busy, 0);
    rst_n = 1;

    // Request accepted in the cycle reset hits: nothing may reach storage.
    hv = 1; hl = 2; hr = 5; hd = 48'h0000_1111_2222;
    #1;
    cmp("pre_reset_ready", host_wr_ready, 1);
    #7;
    rst_n = 0; hv = 0;
    @(posedge clk);
    #1;
    model_reset();
    cmp("reset_mid_write", ws_is_write, 0);
    check_outputs();
    cmp("reset_ready", host_wr_ready | upd_ready, 0);
    rst_n = 1;
    step();

    // Host only, three back-to-back writes.
    for (int i = 0; i < 3; i++) begin
      hv = 1; hl = 0; hr = i; hd = 48'h0001_0002_0003;
      step();
      cmp("host_seq_strobe", ws_is_write, 1);
      cmp("host_seq_row", ws_wr, i);
      cmp("host_seq_data", ws_wd, 48'h0001_0002_0003);
    end
    hv = 0;
    step();
    cmp("host_seq_end", ws_is_write, 0);

    // Contention with training_mode=1.
    tm = 1; hv = 1; uv = 1; hl = 1; hr = 100; ul = 1; ur = 200;
    hd = 48'hAAAA; ud = 48'hBBBB;
    pat = "";
    for (int i = 0; i < 10; i++) begin
      step();
      pat = {pat, gchar(last_g)};
      if (last_g == 1) hr = hr + 1;
      if (last_g == 2) ur = ur + 1;
    end
    check_pat("contention_tm1", "UUUUHHHHUU");
    hv = 0; uv = 0;
    step();

    // Single update cycle, host preferred mode.
    tm = 0; uv = 1; ul = 7; ur = 9; ud = 48'h0123_4567_89AB;
    step();
    cmp("upd_single_strobe", ws_is_update, 1);
    cmp("upd_single_row", ws_ur, 9);
    uv = 0;
    step();
    cmp("upd_single_end", ws_is_update, 0);

    // Both valid from IDLE with training_mode=0: host first.
    hv = 1; uv = 1; hl = 3; hr = 10; ul = 4; ur = 20;
    step();
    cmp("host_first", last_g, 1);
    hr = 11;
    step();
    cmp("pre_hold_strobe", ws_is_write, 1);
    hr = 12;

    // hold_off freezes owner and run length.
    hold_off = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      cmp("hold_no_strobe", ws_is_write | ws_is_update, 0);
    end
    hold_off = 0;
    pat = "";
    for (int i = 0; i < 3; i++) begin
      step();
      pat = {pat, gchar(last_g)};
      if (last_g == 1) hr = hr + 1;
      if (last_g == 2) ur = ur + 1;
    end
    check_pat("hold_resume", "HHU");
    hv = 0; uv = 0;
    step();

    // flush mid update burst, then IDLE preference applies.
    tm = 1; hv = 1; uv = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (last_g == 2) ur = ur + 1;
    end
    flush = 1;
    step();
    cmp("flush_no_grant", last_g, 0);
    flush = 0; tm = 0;
    step();
    cmp("flush_host_pref", last_g, 1);
    hv = 0; uv = 0;
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if (last_g == 1) hv = 0;
      if (last_g == 2) uv = 0;
      if (!hv) begin
        if ($urandom_range(0, 2) != 0) begin
          hv = 1; hl = $urandom_range(0, 7); hr = $urandom;
          hd = {$urandom, $urandom};
        end
      end else if ($urandom_range(0, 19) == 0) begin
        hv = 0;
      end
      if (!uv) begin
        if ($urandom_range(0, 2) != 0) begin
          uv = 1; ul = $urandom_range(0, 7); ur = $urandom;
          ud = {$urandom, $urandom};
        end
      end else if ($urandom_range(0, 19) == 0) begin
        uv = 0;
      end
      if ($urandom_range(0, 15) == 0) tm = ~tm;
      hold_off = ($urandom_range(0, 9) == 0);
      flush    = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
